syn_stamp: RTL
==============

Name: syn_stamp

Overview:
- Event timestamper downstream of the sync-decode stage; consumes its utc_sec/now_ns time base.
- Detects rising edges on an external event line and tags each with {seconds, nanoseconds, sequence}, latency-compensated.
- Queues tags in a small show-ahead FIFO, drained through a valid/ready stream by the packet/readout logic.
- Keeps a saturating overflow status count for the register map.

Parameters:
- DEPTH_LOG2, 3, FIFO depth = 2^DEPTH_LOG2 entries (default 8).
- COMP_NS, 30, ns subtracted from the captured now_ns to cancel synchronizer/detect latency (3 cycles × 10 ns at 100 MHz clk_sys).
- NS_MAX, 999_999_999, last valid now_ns value in a second.

Ports:
- clk_sys  in  1  system clock, 100 MHz
- rst_n  in  1  synchronous active-low reset
- evt_in  in  1  asynchronous event input
- en  in  1  1 = edge detection enabled
- clr  in  1  1-cycle pulse: flush FIFO, zero stu_ovf_cnt
- utc_sec  in  32  current UTC second from sync decode
- now_ns  in  32  current ns within second, 0..NS_MAX
- stamp_vld  out  1  FIFO head valid
- stamp_rdy  in  1  consumer accepts head
- stamp_sec  out  32  head seconds
- stamp_ns  out  32  head nanoseconds
- stamp_seq  out  16  head sequence number
- stu_ovf_cnt  out  8  dropped-event count, saturating
- stu_fill  out  DEPTH_LOG2+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low at a clk_sys edge): sync flops 0, seq counter 0, FIFO empty; stamp_vld=0, stamp_sec/ns/seq=0, stu_ovf_cnt=0, stu_fill=0. Reset mid-operation discards all queued stamps and any stamp in flight.
- Input path: evt_in → s1 → s2 (2-flop synchronizer) → s3 (history). rise = s2 & ~s3 & en.
- Detect cycle: in the cycle rise is 1, utc_sec/now_ns are registered into the compensation stage, and the sequence counter is stamped then incremented. The counter wraps 0xFFFF→0 and counts every detected edge, including dropped ones.
- Compensation (registered, 1 cycle):
  - If now_ns ≥ COMP_NS: ns = now_ns − COMP_NS, sec = utc_sec.
  - Otherwise: ns = now_ns + NS_MAX + 1 − COMP_NS, sec = utc_sec − 1 (32-bit wrap).
- Latency: if evt_in is first sampled high at edge k, the FIFO write happens at edge k+4, and stamp_vld can rise in the cycle after that write.
- en low: rise is forced to 0, no stamps are produced, and the FIFO keeps draining. en falling while a stamp is in the compensation stage still writes that stamp.
- FIFO: show-ahead; the head is always presented on stamp_sec/ns/seq; stamp_vld = (fill ≠ 0).
  - Pop when stamp_vld & stamp_rdy.
  - Push when the compensation stage holds a stamp.
- Full:
  - A push with no pop in the same cycle drops the new stamp and increments stu_ovf_cnt, saturating at 255.
  - Push and pop in the same cycle while full: both succeed, no drop, fill unchanged.
- Empty: a pop is impossible (stamp_vld=0). Push and stamp_rdy together when empty: the stamp is written and appears next cycle with stamp_vld=1.
- Head stability: the head fields are stable while stamp_vld=1 and stamp_rdy=0.
- Pointers: read/write pointers are DEPTH_LOG2 bits and wrap modulo depth; fill is tracked in a separate counter.
- clr: has priority over push and pop in the same cycle. That cycle's push is discarded, not counted as a drop. Next cycle: fill=0, stamp_vld=0, stu_ovf_cnt=0. The sequence counter is not cleared.
- Edges closer than 2 cycles apart may merge in the synchronizer; the minimum resolvable event spacing is 2 clk_sys cycles, i.e. one stamp per low→high of s2.

Test Plan:
- Basic: utc_sec=5, now_ns=1000, now_ns advancing 10 ns per cycle; pulse evt_in for 3 cycles, stamp_rdy=1 → one stamp: sec=5, ns = (now_ns at detect cycle) − 30, seq=0. FIFO write exactly 4 edges after evt_in is sampled high.
- Borrow: now_ns=20 at the detect cycle, utc_sec=7 → stamp sec=6, ns=999_999_990. Also utc_sec=0, now_ns=0 → sec=0xFFFFFFFF, ns=999_999_970.
- Overflow: stamp_rdy=0, 10 events spaced 8 cycles apart → stu_fill=8, stu_ovf_cnt=2, queued seq 0..7. Then stamp_rdy=1 drains seq 0..7 in order, one per cycle; stamp_vld drops after the 8th.
- Full + simultaneous pop: FIFO full, stamp_rdy pulsed in the same cycle as a push → fill stays 8, stu_ovf_cnt unchanged, the new stamp's seq is present at the tail.
- Saturation/clr: 300 events with stamp_rdy=0 → stu_ovf_cnt=255. clr coincident with a push → next cycle fill=0, stu_ovf_cnt=0; the next event carries seq=300.
- en/reset: en=0 during an event → no stamp, seq unchanged. Assert rst_n=0 for one cycle with 3 stamps queued → all outputs 0, and the next event gives seq=0.

Source files
------------

// File: rtl/syn_stamp_if.sv
// Stamp readout stream between the timestamper (master) and the packet/readout logic (slave).
// Show-ahead: the head record is presented whenever stamp_vld is high.
interface syn_stamp_if;
    logic        stamp_vld;
    logic        stamp_rdy;
    logic [31:0] stamp_sec;
    logic [31:0] stamp_ns;
    logic [15:0] stamp_seq;

    modport master (
        output stamp_vld,
        output stamp_sec,
        output stamp_ns,
        output stamp_seq,
        input  stamp_rdy
    );

    modport slave (
        input  stamp_vld,
        input  stamp_sec,
        input  stamp_ns,
        input  stamp_seq,
        output stamp_rdy
    );
endinterface

// File: rtl/syn_stamp.sv
// Event timestamper: synchronizes evt_in, tags rising edges with latency-compensated
// {sec, ns, seq} and queues them in a show-ahead FIFO with a saturating drop counter.
module syn_stamp #(
    parameter int DEPTH_LOG2 = 3,
    parameter int COMP_NS    = 30,
    parameter int NS_MAX     = 999_999_999
) (
    input  logic                clk_sys,
    input  logic                rst_n,
    input  logic                evt_in,
    input  logic                en,
    input  logic                clr,
    input  logic [31:0]         utc_sec,
    input  logic [31:0]         now_ns,
    syn_stamp_if.master         stamp,
    output logic [7:0]          stu_ovf_cnt,
    output logic [DEPTH_LOG2:0] stu_fill
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FILL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] FILL_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
    localparam logic [DEPTH_LOG2:0] FILL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [31:0]         COMP_V    = 32'(COMP_NS);
    localparam logic [31:0]         WRAP_ADD  = 32'(NS_MAX + 1 - COMP_NS);

    typedef struct packed {
        logic [31:0] sec;
        logic [31:0] ns;
        logic [15:0] seq;
    } stamp_t;

    // Borrow a second when the captured ns is too small to subtract the detect latency.
    function automatic stamp_t compensate(input logic [31:0] sec,
                                          input logic [31:0] ns,
                                          input logic [15:0] seq);
        stamp_t r;
        r.seq = seq;
        if (ns >= COMP_V) begin
            r.ns  = ns - COMP_V;
            r.sec = sec;
        end else begin
            r.ns  = ns + WRAP_ADD;
            r.sec = sec - 32'd1;
        end
        return r;
    endfunction

    logic                  s1_q, s2_q, s3_q;
    logic [15:0]           seq_q, seq_d;
    logic                  cap_vld_q;
    logic [31:0]           cap_sec_q, cap_ns_q;
    logic [15:0]           cap_seq_q;
    logic                  cmp_vld_q;
    stamp_t                cmp_q, cmp_d;
    stamp_t                mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   fill_q, fill_d;
    logic [7:0]            ovf_q, ovf_d;
    stamp_t                head_q, head_d;
    logic                  vld_q, vld_d;

    logic rise_s, full_s, pop_s, push_s, drop_s;

    // Next-state logic for detection, FIFO bookkeeping and the registered head.
    always_comb begin
        rise_s = s2_q & ~s3_q & en;
        full_s = (fill_q == FILL_FULL);
        pop_s  = vld_q & stamp.stamp_rdy & ~clr;
        push_s = cmp_vld_q & ~clr & (~full_s | pop_s);
        drop_s = cmp_vld_q & ~clr & full_s & ~pop_s;

        seq_d = rise_s ? (seq_q + 16'd1) : seq_q;
        cmp_d = compensate(cap_sec_q, cap_ns_q, cap_seq_q);

        if (clr) begin
            rd_ptr_d = PTR_ZERO;
            wr_ptr_d = PTR_ZERO;
            fill_d   = FILL_ZERO;
            ovf_d    = 8'd0;
        end else begin
            rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
            wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
            case ({push_s, pop_s})
                2'b10:   fill_d = fill_q + FILL_ONE;
                2'b01:   fill_d = fill_q - FILL_ONE;
                default: fill_d = fill_q;
            endcase
            ovf_d = (drop_s && (ovf_q != 8'hFF)) ? (ovf_q + 8'd1) : ovf_q;
        end

        vld_d = (fill_d != FILL_ZERO);
        // A stamp written into the slot that becomes the head must bypass the memory.
        if (!vld_d) begin
            head_d = '0;
        end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = cmp_q;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            seq_q     <= 16'd0;
            cap_vld_q <= 1'b0;
            cap_sec_q <= 32'd0;
            cap_ns_q  <= 32'd0;
            cap_seq_q <= 16'd0;
            cmp_vld_q <= 1'b0;
            cmp_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= PTR_ZERO;
            rd_ptr_q  <= PTR_ZERO;
            fill_q    <= FILL_ZERO;
            ovf_q     <= 8'd0;
            head_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            s1_q      <= evt_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            seq_q     <= seq_d;
            cap_vld_q <= rise_s;
            if (rise_s) begin
                cap_sec_q <= utc_sec;
                cap_ns_q  <= now_ns;
                cap_seq_q <= seq_q;
            end else begin
                cap_sec_q <= cap_sec_q;
                cap_ns_q  <= cap_ns_q;
                cap_seq_q <= cap_seq_q;
            end
            cmp_vld_q <= cap_vld_q;
            cmp_q     <= cmp_d;
            if (push_s) begin
                mem_q[wr_ptr_q] <= cmp_q;
            end else begin
                mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            ovf_q     <= ovf_d;
            head_q    <= head_d;
            vld_q     <= vld_d;
        end
    end

    assign stamp.stamp_vld = vld_q;
    assign stamp.stamp_sec = head_q.sec;
    assign stamp.stamp_ns  = head_q.ns;
    assign stamp.stamp_seq = head_q.seq;
    assign stu_ovf_cnt     = ovf_q;
    assign stu_fill        = fill_q;

endmodule
